mt_info_reader: RTL and testbench

MT_INFO_READER -- requirements
Module: mt_info_reader

---
 rtl/mt_info_reader_pkg.sv | 26 ++
 rtl/mt_info_decode.sv | 21 ++
 rtl/mt_info_reader.sv | 107 ++++++++++
 tb/tb_mt_info_reader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt_info_reader_pkg.sv
// Shared encodings for the MT info reader: FSM states, special opcodes and word field layout.
package mt_info_reader_pkg;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRead = 3'd1;
  localparam logic [2:0] StCapt = 3'd2;
  localparam logic [2:0] StHold = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpEnd = 4'hF;

  localparam int unsigned OpMsb   = 31;
  localparam int unsigned OpLsb   = 28;
  localparam int unsigned LenMsb  = 27;
  localparam int unsigned LenLsb  = 20;
  localparam int unsigned AddrMsb = 19;
  localparam int unsigned AddrLsb = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  len;
    logic [19:0] addr;
  } mt_fields_t;

endpackage

// File: rtl/mt_info_decode.sv
// Combinational split of an MT info word into op/len/addr plus NOP/END classification.
module mt_info_decode
  import mt_info_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] word_i,
  output mt_fields_t        fields_o,
  output logic              is_nop_o,
  output logic              is_end_o
);

  always_comb begin
    fields_o.op   = word_i[OpMsb:OpLsb];
    fields_o.len  = word_i[LenMsb:LenLsb];
    fields_o.addr = word_i[AddrMsb:AddrLsb];
    is_nop_o      = (fields_o.op == OpNop);
    is_end_o      = (fields_o.op == OpEnd);
  end

endmodule

// File: rtl/mt_info_reader.sv
// Drains the MT info buffer one word at a time, forwarding decoded entries over valid/ready
// and pulsing end_pulse when an END word is consumed.
module mt_info_reader
  import mt_info_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              m01_axi_aresetn,
  input  logic              en,
  input  logic [2:0]        buf_count,
  output logic              RE,
  input  logic [DATA_W-1:0] MT_info_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [7:0]        out_len,
  output logic [19:0]       out_addr,
  output logic              end_pulse,
  output logic [CNT_W-1:0]  fwd_cnt,
  output logic [2:0]        state_check
);

  logic [2:0]       state_q, state_d;
  mt_fields_t       fields_q, fields_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic             re_q, valid_q, end_q;
  logic             arm_q, arm_d;

  mt_fields_t dec_fields;
  logic       dec_nop;
  logic       dec_end;

  mt_info_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .word_i   (MT_info_in),
    .fields_o (dec_fields),
    .is_nop_o (dec_nop),
    .is_end_o (dec_end)
  );

  always_comb begin
    state_d   = state_q;
    fields_d  = fields_q;
    fwd_cnt_d = fwd_cnt_q;
    // Holds off the first read by one edge after reset release.
    arm_d     = 1'b1;
    case (state_q)
      StIdle: begin
        if (arm_q && en && (buf_count != 3'd0)) begin
          state_d = StRead;
        end
      end
      StRead: state_d = StCapt;
      StCapt: begin
        fields_d = dec_fields;
        if (dec_nop) begin
          state_d = StIdle;
        end else if (dec_end) begin
          state_d = StDone;
        end else begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d   = StIdle;
          fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge m01_axi_aresetn) begin
    if (!m01_axi_aresetn) begin
      state_q   <= StIdle;
      fields_q  <= '0;
      fwd_cnt_q <= '0;
      re_q      <= 1'b0;
      valid_q   <= 1'b0;
      end_q     <= 1'b0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fields_q  <= fields_d;
      fwd_cnt_q <= fwd_cnt_d;
      re_q      <= (state_d == StRead);
      valid_q   <= (state_d == StHold);
      end_q     <= (state_d == StDone);
      arm_q     <= arm_d;
    end
  end

  assign RE          = re_q;
  assign out_valid   = valid_q;
  assign out_op      = fields_q.op;
  assign out_len     = fields_q.len;
  assign out_addr    = fields_q.addr;
  assign end_pulse   = end_q;
  assign fwd_cnt     = fwd_cnt_q;
  assign state_check = state_q;

endmodule

// File: tb/tb_mt_info_reader.sv
// Scoreboard bench for mt_info_reader: a buffer model feeds words, a monitor checks handshakes.
module tb_mt_info_reader;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  len;
    logic [19:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  buf_count = 3'd0;
  logic        RE;
  logic [31:0] MT_info_in = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_op;
  logic [7:0]  out_len;
  logic [19:0] out_addr;
  logic        end_pulse;
  logic [15:0] fwd_cnt;
  logic [2:0]  state_check;

  always #5 clk = ~clk;

  mt_info_reader #(
    .DATA_W (32),
    .CNT_W  (16)
  ) dut (
    .clk             (clk),
    .m01_axi_aresetn (rst_n),
    .en              (en),
    .buf_count       (buf_count),
    .RE              (RE),
    .MT_info_in      (MT_info_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_op          (out_op),
    .out_len         (out_len),
    .out_addr        (out_addr),
    .end_pulse       (end_pulse),
    .fwd_cnt         (fwd_cnt),
    .state_check     (state_check)
  );

  exp_t        exp_q[$];
  logic [31:0] buf_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_end = 0;
  logic [15:0] exp_cnt = 16'h0;
  int          re_count = 0;
  int          cyc = 0;
  int          re_cyc = -100;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [3:0] op, input logic [7:0] len, input logic [19:0] addr);
    exp_t e;
    e.op = op;
    e.len = len;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  // Buffer model: pops a word on each RE and presents it during the following cycle.
  always @(negedge clk) begin
    if (rst_n && RE) begin
      re_count++;
      check("re_nonempty", 32'(buf_q.size() != 0), 32'd1);
      if (buf_q.size() != 0) MT_info_in = buf_q.pop_front();
    end
    buf_count = (buf_q.size() > 5) ? 3'd5 : 3'(buf_q.size());
  end

  // Monitor: checks handshakes against the scoreboard, hold stability, end pulses and latency.
  logic pv = 1'b0;
  logic pend = 1'b0;
  logic chk_cnt = 1'b0;
  exp_t pf;
  exp_t mon_e;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pv = 1'b0;
      pend = 1'b0;
      chk_cnt = 1'b0;
    end else begin
      if (chk_cnt) begin
        check("fwd_cnt_after_hs", 32'(fwd_cnt), 32'(exp_cnt));
        chk_cnt = 1'b0;
      end
      if (RE) re_cyc = cyc;
      if (out_valid && !pv) check("valid_latency", 32'(cyc - re_cyc), 32'd2);
      if (out_valid && pv) check("hold_stable", {out_op, out_len, out_addr}, pf);
      if (end_pulse) begin
        check("end_expected", 32'(exp_end > 0), 32'd1);
        if (exp_end > 0) exp_end--;
        check("end_width", 32'(pend), 32'd0);
      end
      if (out_valid && out_ready) begin
        check("entry_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("out_op", 32'(out_op), 32'(mon_e.op));
          check("out_len", 32'(out_len), 32'(mon_e.len));
          check("out_addr", 32'(out_addr), 32'(mon_e.addr));
        end
        exp_cnt = exp_cnt + 16'd1;
        chk_cnt = 1'b1;
      end
      pv = out_valid && !out_ready;
      pf = {out_op, out_len, out_addr};
      pend = end_pulse;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_re"}, 32'(RE), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_fields"}, {out_op, out_len, out_addr}, 32'd0);
    check({tag, "_end"}, 32'(end_pulse), 32'd0);
    check({tag, "_cnt"}, 32'(fwd_cnt), 32'd0);
    check({tag, "_state"}, 32'(state_check), 32'd0);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    exp_q.delete();
    buf_q.delete();
    exp_end = 0;
    exp_cnt = 16'h0;
    repeat (2) @(negedge clk);
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || buf_q.size() != 0 || exp_end != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drain"}, 32'(t < 200), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!out_valid && t < 50) begin
      step();
      t++;
    end
    check({name, "_valid_seen"}, 32'(out_valid), 32'd1);
  endtask

  int re_base;

  initial begin
    #2;
    check_reset_outputs("init");
    repeat (2) @(negedge clk);
    step();
    rst_n = 1'b1;

    // Single word forwarded immediately.
    en = 1'b1;
    out_ready = 1'b1;
    buf_q.push_back(32'h3051_2345);
    expect_entry(4'h3, 8'h05, 20'h12345);
    wait_drain("single");
    check("single_cnt", 32'(fwd_cnt), 32'd1);
    check("single_re_count", re_count, 32'd1);

    // Backpressure for 10 cycles with a second word waiting.
    out_ready = 1'b0;
    re_base = re_count;
    buf_q.push_back(32'h7AB0_0F0F);
    buf_q.push_back(32'h1FF0_0001);
    expect_entry(4'h7, 8'hAB, 20'h00F0F);
    expect_entry(4'h1, 8'hFF, 20'h00001);
    wait_valid("bp");
    repeat (10) step();
    check("bp_valid_held", 32'(out_valid), 32'd1);
    check("bp_no_extra_re", 32'(re_count - re_base), 32'd1);
    check("bp_cnt_held", 32'(fwd_cnt), 32'd1);
    out_ready = 1'b1;
    wait_drain("bp");
    check("bp_cnt", 32'(fwd_cnt), 32'd3);

    // NOP dropped, END pulses, then one entry.
    do_reset();
    buf_q.push_back(32'h0123_4567);
    buf_q.push_back(32'hF000_0000);
    buf_q.push_back(32'h2010_0010);
    exp_end = 1;
    expect_entry(4'h2, 8'h01, 20'h00010);
    wait_drain("nop_end");
    check("nop_end_cnt", 32'(fwd_cnt), 32'd1);

    // Empty buffer never reads.
    for (int i = 0; i < 20; i++) begin
      step();
      check("empty_re", 32'(RE), 32'd0);
      check("empty_state", 32'(state_check), 32'd0);
    end

    // Reset during HOLD discards the entry.
    out_ready = 1'b0;
    buf_q.push_back(32'h5101_1111);
    expect_entry(4'h5, 8'h10, 20'h11111);
    wait_valid("rst_hold");
    check("rst_hold_state", 32'(state_check), 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    check("rst_hold_cnt", 32'(fwd_cnt), 32'd0);
    check("rst_hold_state0", 32'(state_check), 32'd0);
    exp_q.delete();
    exp_cnt = 16'h0;
    buf_q.push_back(32'h4042_0042);
    expect_entry(4'h4, 8'h04, 20'h20042);
    repeat (2) @(negedge clk);
    step();
    rst_n = 1'b1;
    check("rst_rel_state", 32'(state_check), 32'd0);
    out_ready = 1'b1;
    step();
    check("rst_rel_re_edge1", 32'(RE), 32'd0);
    wait_drain("rst_rel");
    check("rst_rel_cnt", 32'(fwd_cnt), 32'd1);

    // Counter wrap from all-ones.
    step();
    force dut.fwd_cnt_q = 16'hFFFF;
    #1;
    release dut.fwd_cnt_q;
    exp_cnt = 16'hFFFF;
    check("wrap_preload", 32'(fwd_cnt), 32'h0000FFFF);
    buf_q.push_back(32'h922A_BCDE);
    expect_entry(4'h9, 8'h22, 20'hABCDE);
    wait_drain("wrap");
    check("wrap_cnt", 32'(fwd_cnt), 32'd0);

    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
